// File: rtl/trace_capture_buffer_pkg.sv
// Shared trace-capture types and default sizing for the processor debug trace path.
package trace_capture_buffer_pkg;

    localparam int TCB_DEPTH_DEFAULT = 16;
    localparam int TCB_SEQ_W_DEFAULT = 16;

    localparam int TCB_PC_W    = 64;
    localparam int TCB_INSTR_W = 32;
    localparam int TCB_ALU_W   = 64;

    // Packed as {pc, instr, alu, seq}; the FIFO stores entries in this bit order.
    typedef struct packed {
        logic [TCB_PC_W-1:0]          pc;
        logic [TCB_INSTR_W-1:0]       instr;
        logic [TCB_ALU_W-1:0]         alu;
        logic [TCB_SEQ_W_DEFAULT-1:0] seq;
    } trace_entry_t;

endpackage

// File: rtl/trace_capture_buffer_fifo_mem.sv
// Trace entry storage: synchronous write port, combinational read at the read pointer.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 176
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Combinational read gives first-word-fall-through at the FIFO output.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Samples the processor debug bus on PC change and queues sequence-numbered trace entries.
module trace_capture_buffer
    import trace_capture_buffer_pkg::*;
#(
    parameter int DEPTH = TCB_DEPTH_DEFAULT,
    parameter int SEQ_W = TCB_SEQ_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     flush,
    input  logic [TCB_PC_W-1:0]      in_pc,
    input  logic [TCB_INSTR_W-1:0]   in_instr,
    input  logic [TCB_ALU_W-1:0]     in_alu,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TCB_PC_W-1:0]      out_pc,
    output logic [TCB_INSTR_W-1:0]   out_instr,
    output logic [TCB_ALU_W-1:0]     out_alu,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [SEQ_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TCB_PC_W + TCB_INSTR_W + TCB_ALU_W + SEQ_W;

    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);

    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [SEQ_W-1:0]    r_seq;
    logic [SEQ_W-1:0]    r_drop;
    logic [TCB_PC_W-1:0] r_last_pc;
    logic                r_pc_valid;
    logic                r_has_data;

    logic          w_capture;
    logic          w_pop;
    logic          w_room;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign out_valid = !empty;
    assign count     = r_count;
    assign drop_count = r_drop;

    assign w_capture = capture_en && (!r_pc_valid || (in_pc != r_last_pc));
    assign w_pop     = out_valid && out_ready && !flush;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_room    = !full || (out_valid && out_ready);
    assign w_push    = w_capture && w_room && !flush;
    assign w_drop    = w_capture && !w_room && !flush;

    assign w_wr_entry = {in_pc, in_instr, in_alu, r_seq};

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // Storage is never reset, so outputs are forced to zero until something is written.
    assign {out_pc, out_instr, out_alu, out_seq} = r_has_data ? w_rd_entry : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_drop     <= '0;
            r_last_pc  <= '0;
            r_pc_valid <= 1'b0;
            r_has_data <= 1'b0;
        end else begin
            if (w_capture) begin
                r_last_pc  <= in_pc;
                r_pc_valid <= 1'b1;
                r_seq      <= r_seq + SEQ_ONE;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + SEQ_ONE;
            end
            if (w_push) begin
                r_has_data <= 1'b1;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed self-checking bench for trace_capture_buffer (DEPTH=16, SEQ_W=16).
module tb_trace_capture_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic        flush;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic [63:0] in_alu;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [63:0] out_alu;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    trace_capture_buffer #(
        .DEPTH (16),
        .SEQ_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .flush      (flush),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_alu     (in_alu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_alu    (out_alu),
        .out_seq    (out_seq),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_instr(input logic [63:0] p);
        return 32'hC0DE_0000 | {16'h0, p[15:0]};
    endfunction

    function automatic logic [63:0] f_alu(input logic [63:0] p);
        return p * 64'd3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [63:0] p);
        in_pc    = p;
        in_instr = f_instr(p);
        in_alu   = f_alu(p);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    initial begin
        int k;
        int n_cap;
        logic [63:0] exp_pc;
        logic [15:0] exp_seq;
        logic        pop;

        reset = 1'b1; capture_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_pc(64'h0);
        tick(); tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h0);
        check("rst_out_seq", 64'(out_seq), 64'h0);
        check("rst_drop", 64'(drop_count), 64'h0);

        // PC 0,4,4,8 with a ready consumer: three entries, no duplicate for the repeat.
        reset = 1'b0; capture_en = 1'b1; out_ready = 1'b1;
        set_pc(64'h0); tick();
        check("t27_valid0", 64'(out_valid), 64'd1);
        check("t27_instr0", 64'(out_instr), 64'(f_instr(64'h0)));
        check("t27_seq0", 64'(out_seq), 64'd0);
        check("t27_count0", 64'(count), 64'd1);
        set_pc(64'h4); tick();
        check("t27_pc1", out_pc, 64'h4);
        check("t27_seq1", 64'(out_seq), 64'd1);
        check("t27_count1", 64'(count), 64'd1);
        set_pc(64'h4); tick();
        check("t27_nodup", 64'(empty), 64'd1);
        set_pc(64'h8); tick();
        check("t27_pc2", out_pc, 64'h8);
        check("t27_seq2", 64'(out_seq), 64'd2);
        check("t27_alu2", out_alu, 64'h18);
        capture_en = 1'b0; tick();
        check("t27_drained", 64'(empty), 64'd1);

        // Fill to full with a stalled consumer, then overflow by one.
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b0; capture_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_pc(64'h1000 + 64'(4 * i)); tick();
        end
        check("t28_full", 64'(full), 64'd1);
        check("t28_count", 64'(count), 64'd16);
        check("t28_head_seq", 64'(out_seq), 64'd0);
        set_pc(64'h1040); tick();
        check("t28_drop", 64'(drop_count), 64'd1);
        check("t28_count_ovf", 64'(count), 64'd16);

        // Full with simultaneous pop: push accepted, occupancy unchanged.
        out_ready = 1'b1;
        set_pc(64'h1044); tick();
        check("t29_count", 64'(count), 64'd16);
        check("t29_drop", 64'(drop_count), 64'd1);
        check("t29_head_seq", 64'(out_seq), 64'd1);
        capture_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_pc  = (i < 15) ? 64'h1004 + 64'(4 * i) : 64'h1044;
            exp_seq = (i < 15) ? 16'(i + 1) : 16'd17;
            check("t29_drain_pc", out_pc, exp_pc);
            check("t29_drain_seq", 64'(out_seq), 64'(exp_seq));
            check("t29_drain_alu", out_alu, f_alu(exp_pc));
            tick();
        end
        check("t29_empty", 64'(empty), 64'd1);

        // Ready toggling each cycle, a new PC every other cycle: 40 captures, no loss.
        reset = 1'b1; tick(); reset = 1'b0;
        k = 0; n_cap = 0;
        for (int c = 0; c < 90; c++) begin
            check("t30_valid", 64'(out_valid), 64'(n_cap > k));
            if (n_cap > k) begin
                check("t30_pc", out_pc, 64'h4000 + 64'(4 * k));
                check("t30_seq", 64'(out_seq), 64'(k));
            end
            out_ready  = ~c[0];
            capture_en = (c < 80);
            if (c < 80) set_pc(64'h4000 + 64'(4 * (c / 2)));
            pop = (n_cap > k) && out_ready;
            tick();
            if (pop) k++;
            if ((c < 80) && (c % 2 == 0)) n_cap++;
        end
        check("t30_all_out", 64'(k), 64'd40);
        check("t30_drop", 64'(drop_count), 64'd0);
        check("t30_empty", 64'(empty), 64'd1);

        // Flush at count 5 keeps the sequence counter running.
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b0; capture_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pc(64'h2000 + 64'(4 * i)); tick();
        end
        check("t31_count5", 64'(count), 64'd5);
        capture_en = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        check("t31_empty", 64'(empty), 64'd1);
        check("t31_count", 64'(count), 64'd0);
        check("t31_valid", 64'(out_valid), 64'd0);
        capture_en = 1'b1;
        set_pc(64'h2020); tick();
        check("t31_valid2", 64'(out_valid), 64'd1);
        check("t31_seq", 64'(out_seq), 64'd5);
        check("t31_pc", out_pc, 64'h2020);

        // Reset mid-drain at count 7 with a nonzero drop counter.
        for (int i = 0; i < 15; i++) begin
            set_pc(64'h2100 + 64'(4 * i)); tick();
        end
        check("t32_full", 64'(full), 64'd1);
        set_pc(64'h2200); tick();
        check("t32_drop1", 64'(drop_count), 64'd1);
        capture_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("t32_count7", 64'(count), 64'd7);
        check("t32_head_seq", 64'(out_seq), 64'd14);
        reset = 1'b1; capture_en = 1'b1; set_pc(64'h2200); tick();
        check("t32_count", 64'(count), 64'd0);
        check("t32_valid", 64'(out_valid), 64'd0);
        check("t32_drop", 64'(drop_count), 64'd0);
        check("t32_out_seq0", 64'(out_seq), 64'd0);
        check("t32_out_pc0", out_pc, 64'h0);
        reset = 1'b0; tick();
        check("t32_valid2", 64'(out_valid), 64'd1);
        check("t32_seq", 64'(out_seq), 64'd0);
        check("t32_pc", out_pc, 64'h2200);
        check("t32_count1", 64'(count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
